// File: rtl/noise_acq_sampler.sv
// noise_acq_sampler: paces ADC conversions inside the n_acq window, streams each sample out and sums them.
// Latency: first adc_conv 1 cycle after the registered start edge; dout/dout_valid 1 cycle after adc_valid.
// Backpressure: dout is a single holding register; an unconsumed sample is overwritten and overrun is set.
module noise_acq_sampler #(
    parameter int CLK_DIV     = 40,
    parameter int ADC_W       = 12,
    parameter int ACC_W       = 32,
    parameter int MAX_SAMPLES = 1024
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             n_acq,
    output logic             adc_conv,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [ACC_W-1:0] acc_sum,
    output logic [15:0]      sample_cnt,
    output logic             acq_done,
    output logic             overrun,
    output logic             timeout_err,
    output logic             sat
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [15:0]      CNT_CAP  = 16'(MAX_SAMPLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             n_acq_q;
    logic             start_pend_q;
    logic             stop_seen_q;
    logic [DIV_W-1:0] div_q;

    logic             n_acq_rise;
    logic             start;
    logic             accept;
    logic             tmo;
    logic             div_last;
    logic             stop_req;
    logic             cap_hit;
    logic             xfer;
    logic [15:0]      cnt_next;
    logic [ACC_W:0]   sum_ext;

    // Window edge detection. The registered copy resets high so a window
    // that is already open when reset releases is not mistaken for a new one.
    assign n_acq_rise = n_acq & ~n_acq_q;

    // A start is taken only from IDLE, either from a live edge or one
    // remembered while DONE was being signalled.
    assign start    = (state_q == IDLE) && (n_acq_rise || start_pend_q);
    assign accept   = (state_q == CONV) && adc_valid;
    assign tmo      = (state_q == CONV) && !adc_valid && div_last;
    assign div_last = (div_q == DIV_LAST);
    assign stop_req = !n_acq || stop_seen_q;
    assign cnt_next = sample_cnt + 16'd1;
    assign cap_hit  = accept && (cnt_next == CNT_CAP);
    assign xfer     = dout_valid && dout_ready;

    // One extra bit catches accumulator overflow for saturation.
    assign sum_ext  = {1'b0, acc_sum} + {{(ACC_W + 1 - ADC_W){1'b0}}, adc_data};

    // State register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a conversion in flight always completes before stopping.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!n_acq) begin
                    state_d = DONE;
                end else if (div_q == '0) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (accept) begin
                    state_d = (cap_hit || stop_req) ? DONE : RUN;
                end else if (tmo) begin
                    state_d = stop_req ? DONE : RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: convert pulse on the divider zero slot, done pulse for the single DONE cycle.
    always_comb begin
        adc_conv = 1'b0;
        acq_done = 1'b0;
        case (state_q)
            RUN:     adc_conv = n_acq && (div_q == '0);
            DONE:    acq_done = 1'b1;
            default: begin
                adc_conv = 1'b0;
                acq_done = 1'b0;
            end
        endcase
    end

    // Edge-detect register and the edge remembered while in DONE.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            n_acq_q      <= 1'b1;
            start_pend_q <= 1'b0;
        end else begin
            n_acq_q <= n_acq;
            if (start) begin
                start_pend_q <= 1'b0;
            end else if ((state_q == DONE) && n_acq_rise) begin
                start_pend_q <= 1'b1;
            end
        end
    end

    // Remember a window close seen mid-conversion, in case n_acq bounces back high.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stop_seen_q <= 1'b0;
        end else if ((state_q == CONV) && (state_d == CONV)) begin
            stop_seen_q <= stop_seen_q | !n_acq;
        end else begin
            stop_seen_q <= 1'b0;
        end
    end

    // Sample-period divider: free-runs through RUN and CONV so the conversion
    // schedule does not slip when a sample arrives early or times out.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (start) begin
            div_q <= '0;
        end else if ((state_q == RUN) || (state_q == CONV)) begin
            div_q <= div_last ? '0 : (div_q + DIV_ONE);
        end else begin
            div_q <= '0;
        end
    end

    // Window totals: cleared on start, held after the window for firmware to read.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum    <= '0;
            sample_cnt <= '0;
            sat        <= 1'b0;
        end else if (start) begin
            acc_sum    <= '0;
            sample_cnt <= '0;
            sat        <= 1'b0;
        end else if (accept) begin
            sample_cnt <= cnt_next;
            if (sum_ext[ACC_W]) begin
                acc_sum <= '1;
                sat     <= 1'b1;
            end else begin
                acc_sum <= sum_ext[ACC_W-1:0];
            end
        end
    end

    // Sticky error flags, cleared on start.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (start) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (accept && dout_valid && !dout_ready) begin
                overrun <= 1'b1;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Output holding register: a new sample always wins over a pending one;
    // a transfer in the same cycle as a new sample is not an overrun.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (accept) begin
            dout       <= adc_data;
            dout_valid <= 1'b1;
        end else if (xfer) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noise_acq_sampler.sv
`timescale 1ns/1ps
// Directed bench for noise_acq_sampler: main instance plus cap and saturation instances.
module tb_noise_acq_sampler;

    logic        clk_sys;
    logic        rst_n;
    logic        n_acq_a;
    logic        n_acq_b;
    logic        adc_valid;
    logic [11:0] adc_val;
    logic        dout_ready;

    logic        conv_a, dv_a, done_a, ov_a, to_a, sat_a;
    logic [11:0] dout_a;
    logic [31:0] acc_a;
    logic [15:0] cnt_a;

    logic        conv_c, dv_c, done_c, ov_c, to_c, sat_c;
    logic [11:0] dout_c;
    logic [31:0] acc_c;
    logic [15:0] cnt_c;

    logic        conv_s, dv_s, done_s, ov_s, to_s, sat_s;
    logic [11:0] dout_s;
    logic [12:0] acc_s;
    logic [15:0] cnt_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int conv_a_n = 0;
    int done_a_n = 0;
    int conv_c_n = 0;
    int done_c_n = 0;
    int conv_s_n = 0;
    int conv_a_cyc [0:255];

    int   adc_dly = 2;
    logic adc_en  = 1'b1;
    int   adc_cnt = 0;

    noise_acq_sampler #(.CLK_DIV(8)) u_dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .n_acq(n_acq_a), .adc_conv(conv_a),
        .adc_valid(adc_valid), .adc_data(adc_val), .dout(dout_a), .dout_valid(dv_a),
        .dout_ready(dout_ready), .acc_sum(acc_a), .sample_cnt(cnt_a), .acq_done(done_a),
        .overrun(ov_a), .timeout_err(to_a), .sat(sat_a)
    );

    noise_acq_sampler #(.CLK_DIV(8), .MAX_SAMPLES(4)) u_cap (
        .clk_sys(clk_sys), .rst_n(rst_n), .n_acq(n_acq_b), .adc_conv(conv_c),
        .adc_valid(adc_valid), .adc_data(adc_val), .dout(dout_c), .dout_valid(dv_c),
        .dout_ready(1'b1), .acc_sum(acc_c), .sample_cnt(cnt_c), .acq_done(done_c),
        .overrun(ov_c), .timeout_err(to_c), .sat(sat_c)
    );

    noise_acq_sampler #(.CLK_DIV(8), .ACC_W(13), .MAX_SAMPLES(3)) u_sat (
        .clk_sys(clk_sys), .rst_n(rst_n), .n_acq(n_acq_b), .adc_conv(conv_s),
        .adc_valid(adc_valid), .adc_data(adc_val), .dout(dout_s), .dout_valid(dv_s),
        .dout_ready(1'b1), .acc_sum(acc_s), .sample_cnt(cnt_s), .acq_done(done_s),
        .overrun(ov_s), .timeout_err(to_s), .sat(sat_s)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Cycle number: value seen after the N-th rising edge.
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if (conv_a) begin
            if (conv_a_n < 256) conv_a_cyc[conv_a_n] = cyc;
            conv_a_n++;
        end
        if (done_a) done_a_n++;
        if (conv_c) conv_c_n++;
        if (done_c) done_c_n++;
        if (conv_s) conv_s_n++;
    end

    // ADC model: answers adc_dly cycles after a convert pulse when enabled.
    always @(negedge clk_sys) begin
        adc_valid = 1'b0;
        if (adc_cnt != 0) begin
            adc_cnt--;
            if (adc_cnt == 0) adc_valid = 1'b1;
        end
        if ((conv_a || conv_c) && adc_en) adc_cnt = adc_dly;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k0;
        int d0;
        int s0;
        int kc;
        int dc;
        int ks;

        rst_n = 1'b0; n_acq_a = 1'b0; n_acq_b = 1'b0;
        dout_ready = 1'b1; adc_val = 12'h123;
        tick(2);
        chk("rst_conv", 32'(conv_a), 32'h0);
        chk("rst_dv", 32'(dv_a), 32'h0);
        chk("rst_acc", acc_a, 32'h0);
        chk("rst_cnt", 32'(cnt_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_flags", 32'({ov_a, to_a, sat_a}), 32'h0);
        rst_n = 1'b1;
        tick(3);

        // Normal window, consumer always ready.
        k0 = conv_a_n; d0 = done_a_n; s0 = cyc;
        n_acq_a = 1'b1;
        tick(40); n_acq_a = 1'b0;
        tick(10);
        chk("t1_conv_cnt", conv_a_n - k0, 32'd5);
        chk("t1_first_conv", conv_a_cyc[k0] - s0, 32'd1);
        for (int i = 1; i < 5; i++)
            chk("t1_conv_gap", conv_a_cyc[k0 + i] - conv_a_cyc[k0 + i - 1], 32'd8);
        chk("t1_acc", acc_a, 32'h5AF);
        chk("t1_cnt", 32'(cnt_a), 32'd5);
        chk("t1_done", done_a_n - d0, 32'd1);
        chk("t1_flags", 32'({ov_a, to_a, sat_a}), 32'h0);
        chk("t1_dout", 32'(dout_a), 32'h123);
        chk("t1_dv", 32'(dv_a), 32'h0);

        // Same window, consumer stalled.
        dout_ready = 1'b0;
        k0 = conv_a_n; d0 = done_a_n;
        n_acq_a = 1'b1;
        tick(4);
        chk("t2_cnt1", 32'(cnt_a), 32'd1);
        chk("t2_dv1", 32'(dv_a), 32'h1);
        chk("t2_ov_first", 32'(ov_a), 32'h0);
        tick(8);
        chk("t2_cnt2", 32'(cnt_a), 32'd2);
        chk("t2_ov_second", 32'(ov_a), 32'h1);
        tick(28); n_acq_a = 1'b0;
        tick(10);
        chk("t2_acc", acc_a, 32'h5AF);
        chk("t2_cnt", 32'(cnt_a), 32'd5);
        chk("t2_dv", 32'(dv_a), 32'h1);
        chk("t2_dout", 32'(dout_a), 32'h123);
        chk("t2_done", done_a_n - d0, 32'd1);
        dout_ready = 1'b1;
        tick(1);
        chk("t2_dv_drain", 32'(dv_a), 32'h0);

        // ADC never answers.
        adc_en = 1'b0;
        k0 = conv_a_n; d0 = done_a_n;
        n_acq_a = 1'b1;
        tick(2);
        chk("t3_ov_cleared", 32'(ov_a), 32'h0);
        tick(6);
        chk("t3_to_early", 32'(to_a), 32'h0);
        tick(1);
        chk("t3_to_set", 32'(to_a), 32'h1);
        tick(31); n_acq_a = 1'b0;
        tick(10);
        chk("t3_conv_cnt", conv_a_n - k0, 32'd5);
        chk("t3_acc", acc_a, 32'h0);
        chk("t3_cnt", 32'(cnt_a), 32'd0);
        chk("t3_done", done_a_n - d0, 32'd1);
        adc_en = 1'b1;

        // Sample cap and accumulator saturation, n_acq held high.
        adc_val = 12'hFFF;
        kc = conv_c_n; dc = done_c_n; ks = conv_s_n;
        n_acq_b = 1'b1;
        tick(28);
        chk("t4_cap_done_pulse", 32'(done_c), 32'h1);
        tick(60);
        chk("t4_cap_conv", conv_c_n - kc, 32'd4);
        chk("t4_cap_done", done_c_n - dc, 32'd1);
        chk("t4_cap_acc", acc_c, 32'h3FFC);
        chk("t4_cap_cnt", 32'(cnt_c), 32'd4);
        chk("t4_cap_sat", 32'(sat_c), 32'h0);
        chk("t4_sat_conv", conv_s_n - ks, 32'd3);
        chk("t4_sat_acc", 32'(acc_s), 32'h1FFF);
        chk("t4_sat_flag", 32'(sat_s), 32'h1);
        chk("t4_sat_cnt", 32'(cnt_s), 32'd3);
        n_acq_b = 1'b0;
        tick(3);
        n_acq_b = 1'b1;
        tick(2);
        chk("t4_restart_conv", conv_c_n - kc, 32'd5);
        chk("t4_restart_cnt", 32'(cnt_c), 32'd0);
        chk("t4_restart_acc", acc_c, 32'h0);
        chk("t4_restart_sat", 32'(sat_s), 32'h0);
        tick(40); n_acq_b = 1'b0;
        tick(5);

        // Window closes during a conversion; late sample still counted.
        adc_val = 12'h0A5; adc_dly = 4;
        k0 = conv_a_n;
        n_acq_a = 1'b1;
        tick(2); n_acq_a = 1'b0;
        tick(4);
        chk("t5_done_pulse", 32'(done_a), 32'h1);
        chk("t5_cnt", 32'(cnt_a), 32'd1);
        chk("t5_acc", acc_a, 32'h0A5);
        tick(1);
        chk("t5_done_clear", 32'(done_a), 32'h0);
        chk("t5_conv_cnt", conv_a_n - k0, 32'd1);
        tick(5);

        // Asynchronous reset mid-window.
        adc_val = 12'h123; adc_dly = 2; dout_ready = 1'b0;
        n_acq_a = 1'b1;
        tick(12);
        chk("t6_pre_ov", 32'(ov_a), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_dv", 32'(dv_a), 32'h0);
        chk("t6_rst_dout", 32'(dout_a), 32'h0);
        chk("t6_rst_acc", acc_a, 32'h0);
        chk("t6_rst_cnt", 32'(cnt_a), 32'h0);
        chk("t6_rst_ov", 32'(ov_a), 32'h0);
        tick(2);
        rst_n = 1'b1; dout_ready = 1'b1;
        k0 = conv_a_n;
        tick(20);
        chk("t6_no_conv_after_rst", conv_a_n - k0, 32'd0);
        n_acq_a = 1'b0;
        tick(2); n_acq_a = 1'b1;
        tick(2);
        chk("t6_conv_new_edge", conv_a_n - k0, 32'd1);
        n_acq_a = 1'b0;
        tick(10);

        // Rising edge during the DONE cycle is not lost.
        adc_val = 12'h010;
        d0 = done_a_n;
        n_acq_a = 1'b1;
        tick(6); n_acq_a = 1'b0;
        tick(1);
        chk("t7_done_cycle", 32'(done_a), 32'h1);
        n_acq_a = 1'b1;
        tick(1);
        chk("t7_idle_done", 32'(done_a), 32'h0);
        chk("t7_hold_cnt", 32'(cnt_a), 32'd1);
        chk("t7_hold_acc", acc_a, 32'h010);
        tick(1);
        chk("t7_clear_cnt", 32'(cnt_a), 32'd0);
        chk("t7_clear_acc", acc_a, 32'h0);
        tick(3);
        chk("t7_new_cnt", 32'(cnt_a), 32'd1);
        chk("t7_new_acc", acc_a, 32'h010);
        n_acq_a = 1'b0;
        tick(10);
        chk("t7_done_total", done_a_n - d0, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
